// File: rtl/pes_usr_if.sv
// Bus bundle for the universal shift register.
// in/cnt flow master->slave, q flows slave->master.
interface pes_usr_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in;
  logic [1:0]       cnt;
  logic [WIDTH-1:0] q;

  modport master (
    output in,
    output cnt,
    input  q
  );

  modport slave (
    input  in,
    input  cnt,
    output q
  );
endinterface

// File: rtl/pes_usr.sv
// Universal shift register: hold, shift right, shift left or load.
// Ports: clk, rst (async, active-low), bus.in/bus.cnt in, bus.q out.
module pes_usr #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  pes_usr_if.slave   bus
);
  logic [WIDTH-1:0] q_r;

  assign bus.q = q_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= '0;
    end else begin
      unique case (bus.cnt)
        2'b00: q_r <= q_r;
        // serial-in at MSB comes from in's MSB
        2'b01: q_r <= {bus.in[WIDTH-1],
                       q_r[WIDTH-1:1]};
        // serial-in at LSB comes from in's LSB
        2'b10: q_r <= {q_r[WIDTH-2:0],
                       bus.in[0]};
        2'b11: q_r <= bus.in;
        default: q_r <= 'x;
      endcase
    end
  end
endmodule

// File: tb/tb_pes_usr.sv
// Self-checking bench for pes_usr.
// Directed sequences plus randomized run against a model.
module tb_pes_usr;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [W-1:0] model;

  pes_usr_if #(.WIDTH(W)) bus ();

  pes_usr #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string        tag,
    input logic [W-1:0] obs,
    input logic [W-1:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b",
               tag, obs, exp);
    end
  endtask

  // Reference: next value from mode rules, plain arithmetic.
  function automatic logic [W-1:0] ref_next(
    input logic [W-1:0] cur,
    input logic [1:0]   mode,
    input logic [W-1:0] din
  );
    int v;
    int mask;
    mask = (1 << W) - 1;
    v = int'(cur);
    case (mode)
      2'd0: v = v;
      2'd1: v = (v / 2) + (din[W-1] ? (1 << (W-1)) : 0);
      2'd2: v = ((v * 2) & mask) + (din[0] ? 1 : 0);
      default: v = int'(din);
    endcase
    return v[W-1:0];
  endfunction

  task automatic step(
    input string        tag,
    input logic [1:0]   mode,
    input logic [W-1:0] din,
    input logic [W-1:0] exp
  );
    bus.cnt = mode;
    bus.in  = din;
    @(posedge clk);
    #1;
    check(tag, bus.q, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.cnt = 2'b00;
    bus.in  = '0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    // put an arbitrary value in q first
    step("preload", 2'b11, 4'b1011, 4'b1011);

    // 1: async reset without an edge
    #2;
    rst = 1'b0;
    #1;
    check("rst_async", bus.q, 4'b0000);
    #1;
    rst = 1'b1;
    #1;
    check("rst_release", bus.q, 4'b0000);

    // 2: load and hold
    step("load", 2'b11, 4'b1100, 4'b1100);
    step("hold1", 2'b00, 4'b0011, 4'b1100);
    step("hold2", 2'b00, 4'b0101, 4'b1100);

    // 3: shift right with MSB fill
    step("shr1", 2'b01, 4'b1100, 4'b1110);
    step("shr2", 2'b01, 4'b1100, 4'b1111);
    step("shr3", 2'b01, 4'b1100, 4'b1111);

    // 4: reload then shift left with 0 fill
    step("reload", 2'b11, 4'b1100, 4'b1100);
    step("shl1", 2'b10, 4'b1100, 4'b1000);
    step("shl2", 2'b10, 4'b1100, 4'b0000);
    step("shl3", 2'b10, 4'b1100, 4'b0000);

    // 5: shift left with 1 fill from zero
    step("fill1", 2'b10, 4'b0001, 4'b0001);
    step("fill2", 2'b10, 4'b0001, 4'b0011);
    step("fill3", 2'b10, 4'b0001, 4'b0111);
    step("fill4", 2'b10, 4'b0001, 4'b1111);

    // 6: reset mid-shift, hold, resume from zero
    step("pre6", 2'b01, 4'b1000, 4'b1111);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid", bus.q, 4'b0000);
    @(posedge clk);
    #1;
    check("rst_hold", bus.q, 4'b0000);
    #2;
    rst = 1'b1;
    bus.cnt = 2'b10;
    bus.in  = 4'b0001;
    @(posedge clk);
    #1;
    check("resume", bus.q, 4'b0001);

    // randomized run against the model
    model = bus.q;
    for (int i = 0; i < 300; i++) begin
      logic [1:0]   m;
      logic [W-1:0] d;
      m = 2'($urandom_range(3));
      d = W'($urandom);
      model = ref_next(model, m, d);
      step("rand", m, d, model);
      if ($urandom_range(19) == 0) begin
        #2;
        rst = 1'b0;
        #1;
        model = '0;
        check("rand_rst", bus.q, model);
        #1;
        rst = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
